// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate enable, h/v counters, active-low syncs and
// blanked, registered colour. Define VGA_FRAME_CNT_EN to add an 8-bit frame counter output.
module vga_sync_gen #(
  parameter int unsigned H_DISP = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       rgb_in,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0]       frame_cnt,
`endif
  output logic [2:0]       rgb_out
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HLast      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HDisp      = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] VDisp      = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HSyncFirst = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HSyncLast  = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VSyncFirst = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VSyncLast  = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  logic             div_q, p_tick_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             von_q, von_d;
  logic             fs_q, wrap_d;
  logic [2:0]       rgb_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    if (p_tick_q) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d    = '0;
          wrap_d = 1'b1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
    // Decode from next counts so syncs and blanking move on the same edge as the counters.
    von_d   = (x_d < HDisp) && (y_d < VDisp);
    hsync_d = !((x_d >= HSyncFirst) && (x_d <= HSyncLast));
    vsync_d = !((y_d >= VSyncFirst) && (y_d <= VSyncLast));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= 1'b0;
      p_tick_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      von_q    <= 1'b1;
      fs_q     <= 1'b0;
      rgb_q    <= 3'b000;
    end else begin
      div_q    <= ~div_q;
      p_tick_q <= div_q;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      von_q    <= von_d;
      fs_q     <= wrap_d;
      if (p_tick_q) begin
        rgb_q <= von_d ? rgb_in : 3'b000;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 8'd0;
    end else if (wrap_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign p_tick      = p_tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign video_on    = von_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken 16x12 raster; expected outputs come from a
// closed-form model indexed by clock edges since reset release.
module tb_vga_sync_gen;

  localparam int HD = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VD = 6, VFP = 2, VS = 2, VBP = 2;
  localparam int W = 10;
  localparam int HT = HD + HFP + HS + HBP;
  localparam int VT = VD + VFP + VS + VBP;
  localparam int FRAME = 2 * HT * VT;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   rgb_in = 3'b000;
  logic         p_tick, video_on, hsync, vsync, frame_start;
  logic [W-1:0] pixel_x, pixel_y;
  logic [2:0]   rgb_out;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]   frame_cnt;
`endif

  vga_sync_gen #(
    .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CNT_W(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rgb_in     (rgb_in),
    .p_tick     (p_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .rgb_out    (rgb_out)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic         pt;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         von;
    logic         hs;
    logic         vs;
    logic         fs;
    logic [2:0]   rgb;
    logic [7:0]   fc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Model: after edge k of the released run, s = (k-1)/2 pixel steps have occurred.
  int         k = 0, s, mx, my, frames = 0;
  logic [2:0] last_rgb = 3'b000;
  logic       mvon;
  exp_t       me;

  always @(posedge clk) begin
    if (!rst) begin
      k = 0;
      frames = 0;
      last_rgb = 3'b000;
    end else begin
      k++;
    end
    s  = (k >= 1) ? (k - 1) / 2 : 0;
    mx = s % HT;
    my = (s / HT) % VT;
    mvon = (mx < HD) && (my < VD);
    me.pt  = (k >= 2) && (k % 2 == 0);
    me.x   = W'(mx);
    me.y   = W'(my);
    me.von = mvon;
    me.hs  = !((mx >= HD + HFP) && (mx < HD + HFP + HS));
    me.vs  = !((my >= VD + VFP) && (my < VD + VFP + VS));
    me.fs  = (k >= 3) && (k % 2 == 1) && (s % (HT * VT) == 0);
    if (me.fs) frames++;
    if ((k >= 3) && (k % 2 == 1)) last_rgb = mvon ? rgb_in : 3'b000;
    me.rgb = last_rgb;
    me.fc  = 8'(frames);
    q.push_back(me);
  end

  exp_t ce;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("p_tick", int'(p_tick), int'(ce.pt));
      chk("pixel_x", int'(pixel_x), int'(ce.x));
      chk("pixel_y", int'(pixel_y), int'(ce.y));
      chk("video_on", int'(video_on), int'(ce.von));
      chk("hsync", int'(hsync), int'(ce.hs));
      chk("vsync", int'(vsync), int'(ce.vs));
      chk("frame_start", int'(frame_start), int'(ce.fs));
      chk("rgb_out", int'(rgb_out), int'(ce.rgb));
`ifdef VGA_FRAME_CNT_EN
      chk("frame_cnt", int'(frame_cnt), int'(ce.fc));
`endif
    end
  end

  logic [2:0] colour;
  logic       prev_vs;
  int         found;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Colour sweep: new colour at each vsync falling edge.
    colour  = 3'd1;
    prev_vs = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clk);
      if (prev_vs && !vsync) begin
        rgb_in = colour;
        colour = (colour == 3'd7) ? 3'd1 : colour + 3'd1;
      end
      prev_vs = vsync;
    end

    // Per-clock random colour exposes any pixel skew in the colour path.
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      rgb_in = 3'($urandom_range(0, 7));
    end

    // Async reset mid-line while hsync is low.
    found = 0;
    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      @(negedge clk);
      if (pixel_x == W'(11) && pixel_y == W'(3)) found = 1;
    end
    chk("reach_mid_line", found, 1);
    chk("hsync_low_before_reset", int'(hsync), 0);
    #3 rst = 1'b0;
    #1;
    chk("async_hsync", int'(hsync), 1);
    chk("async_pixel_x", int'(pixel_x), 0);
    chk("async_pixel_y", int'(pixel_y), 0);
    chk("async_p_tick", int'(p_tick), 0);
    chk("async_rgb_out", int'(rgb_out), 0);
    chk("async_video_on", int'(video_on), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk);
      rgb_in = 3'($urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
